// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle processor.
// Opcodes, control FSM states and datapath select encodings.
package cpu_pkg;

  localparam int NUM_OPS = 16;
  localparam int OP_W    = $clog2(NUM_OPS);

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OP_W-1:0] OP_LW   = 4'h5;
  localparam logic [OP_W-1:0] OP_SW   = 4'h6;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h7;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h8;
  localparam logic [OP_W-1:0] OP_J    = 4'h9;
  localparam logic [OP_W-1:0] OP_CMP  = 4'hA;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_REG_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_CMP      = 4'd11,
    S_HALT     = 4'd12
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM4 = 2'b10;
  localparam logic [1:0] SRCB_IMM8 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // R-type opcodes 0..3 line up with ALU ops add/sub/and/or
  function automatic logic [2:0] rtype_alu(
    input logic [OP_W-1:0] op
  );
    return {1'b0, op[1:0]};
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the datapath enables and selects (Moore outputs).
module control_unit
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  output logic            writeIR,
  output logic            writeRegFile,
  output logic            CRwrite,
  output logic            memRead,
  output logic            memWrite,
  output logic            IorD,
  output logic            memToReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            PCWrite,
  output logic [1:0]      PCSource,
  output logic            halted
);

  state_e          r_state;
  state_e          w_next;
  logic [OP_W-1:0] r_op;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode;
    end
  end

  // DECODE dispatches on the live opcode; later states use the latched copy
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB,
          OP_AND, OP_OR:  w_next = S_EXEC_R;
          OP_ADDI:        w_next = S_EXEC_I;
          OP_LW, OP_SW:   w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
          OP_CMP:         w_next = S_CMP;
          OP_HALT:        w_next = S_HALT;
          default:        w_next = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_REG_WB;
      S_MEM_ADDR: begin
        w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: w_next = S_MEM_WB;
      S_MEM_WR, S_MEM_WB, S_REG_WB,
      S_BRANCH, S_JUMP, S_CMP: w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_comb begin
    writeIR      = 1'b0;
    writeRegFile = 1'b0;
    CRwrite      = 1'b0;
    memRead      = 1'b0;
    memWrite     = 1'b0;
    IorD         = 1'b0;
    memToReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_REG;
    ALUOp        = ALU_ADD;
    PCWrite      = 1'b0;
    PCSource     = PCSRC_ALU;
    halted       = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          writeIR = 1'b1;
          ALUSrcB = SRCB_ONE;
          PCWrite = 1'b1;
        end
        S_DECODE: ALUSrcB = SRCB_IMM8;
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = rtype_alu(r_op);
        end
        S_EXEC_I, S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM4;
        end
        S_MEM_RD: begin
          memRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          memWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_MEM_WB: begin
          writeRegFile = 1'b1;
          memToReg     = 1'b1;
        end
        S_REG_WB: writeRegFile = 1'b1;
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = ALU_SUB;
          PCSource = PCSRC_OUT;
          PCWrite  = (r_op == OP_BEQ) ? zero : ~zero;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JMP;
        end
        S_CMP: begin
          ALUSrcA      = 1'b1;
          ALUOp        = ALU_SUB;
          writeRegFile = 1'b1;
          CRwrite      = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against an
// instruction-level model of per-cycle control outputs.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       writeIR, writeRegFile, CRwrite, memRead, memWrite;
  logic       IorD, memToReg, ALUSrcA, PCWrite, halted;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  typedef struct packed {
    logic       wir;
    logic       wrf;
    logic       crw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       pcw;
    logic [1:0] pcsrc;
    logic       hlt;
  } ov_t;

  ov_t obs;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .writeIR(writeIR), .writeRegFile(writeRegFile),
    .CRwrite(CRwrite), .memRead(memRead), .memWrite(memWrite),
    .IorD(IorD), .memToReg(memToReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCWrite(PCWrite),
    .PCSource(PCSource), .halted(halted)
  );

  assign obs = '{writeIR, writeRegFile, CRwrite, memRead,
                 memWrite, IorD, memToReg, ALUSrcA, ALUSrcB,
                 ALUOp, PCWrite, PCSource, halted};

  // instruction length in cycles; halt is given a fixed 50-cycle stay
  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6: return 4;
      4'h5:                         return 5;
      4'h7, 4'h8, 4'h9, 4'hA:       return 3;
      4'hF:                         return 52;
      default:                      return 2;
    endcase
  endfunction

  function automatic ov_t expect_at(
    input logic [3:0] op, input int k, input logic z
  );
    ov_t e;
    e = '0;
    if (k == 0) begin
      e.wir = 1; e.mrd = 1; e.srcb = 2'b01; e.pcw = 1;
    end else if (k == 1) begin
      e.srcb = 2'b11;
    end else begin
      case (op)
        4'h0, 4'h1, 4'h2, 4'h3: begin
          if (k == 2) begin
            e.srca = 1;
            e.aluop = (op == 4'h0) ? 3'b000 :
                      (op == 4'h1) ? 3'b001 :
                      (op == 4'h2) ? 3'b010 : 3'b011;
          end else e.wrf = 1;
        end
        4'h4: begin
          if (k == 2) begin e.srca = 1; e.srcb = 2'b10; end
          else e.wrf = 1;
        end
        4'h5: begin
          if (k == 2) begin e.srca = 1; e.srcb = 2'b10; end
          else if (k == 3) begin e.mrd = 1; e.iord = 1; end
          else begin e.wrf = 1; e.m2r = 1; end
        end
        4'h6: begin
          if (k == 2) begin e.srca = 1; e.srcb = 2'b10; end
          else begin e.mwr = 1; e.iord = 1; end
        end
        4'h7, 4'h8: begin
          e.srca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01;
          e.pcw = (op == 4'h7) ? z : !z;
        end
        4'h9: begin e.pcw = 1; e.pcsrc = 2'b10; end
        4'hA: begin
          e.srca = 1; e.aluop = 3'b001; e.wrf = 1; e.crw = 1;
        end
        4'hF: e.hlt = 1;
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string tag, input ov_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inv(input string tag);
    vectors++;
    assert (!(obs.crw && !obs.wrf) && !(obs.mrd && obs.mwr)) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=no_conflict", tag, obs);
    end
  endtask

  // zsel: 0/1 fixes zero, 2 randomizes it each cycle
  task automatic run_instr(input logic [3:0] op, input int zsel,
                           input string tag);
    int n;
    int wir_cnt;
    n = ilen(op);
    wir_cnt = 0;
    for (int k = 0; k < n; k++) begin
      opcode = (k < 2) ? op : 4'($urandom);
      zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      #4;
      chk(tag, expect_at(op, k, zero));
      chk_inv({tag, "_inv"});
      wir_cnt += int'(obs.wir);
      @(posedge clk); #1;
    end
    vectors++;
    assert (wir_cnt == 1) else begin
      miscompares++;
      $error("FAIL %s_wir_count observed=%0d expected=1", tag, wir_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    opcode = 4'h0;
    zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("reset_hold", '0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    run_instr(4'h1, 2, "sub");
    run_instr(4'h5, 2, "lw");
    run_instr(4'h7, 1, "beq_z1");
    run_instr(4'h7, 0, "beq_z0");
    run_instr(4'h8, 1, "bne_z1");
    run_instr(4'h8, 0, "bne_z0");
    run_instr(4'hA, 2, "cmp");
    run_instr(4'hC, 2, "illegal");
    run_instr(4'h6, 2, "sw");
    run_instr(4'h9, 2, "j");

    for (int i = 0; i < 150; i++) begin
      run_instr(4'($urandom_range(0, 14)), 2, "rand");
    end

    // abort a lw in its MEM_RD cycle
    for (int k = 0; k < 3; k++) begin
      opcode = (k < 2) ? 4'h5 : 4'h0;
      zero = 1'($urandom);
      #4;
      chk("lw_pre_abort", expect_at(4'h5, k, zero));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #4;
    chk("lw_abort_rst", '0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(4'h0, 2, "post_abort");

    run_instr(4'hF, 2, "halt");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle control FSM for the 16-bit processor. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the load enables of the instruction register, the register file and the CR register, and the datapath mux and ALU selects. It sits directly downstream of the IR: it consumes the opcode field `instr[15:12]` and the ALU `zero` flag, and produces `writeIR`, `writeRegFile` and `CRwrite`.

## Interface
- `NUM_OPS`, 16, opcode space size (4-bit opcode field)
- `clk` input 1, rising-edge system clock
- `reset` input 1, synchronous, active-high
- `opcode` input 4, IR bits [15:12]
- `zero` input 1, ALU result == 0, valid in the BRANCH cycle
- `writeIR` output 1, IR load enable
- `writeRegFile` output 1, register-file write enable
- `CRwrite` output 1, CR write enable; only asserted together with `writeRegFile`
- `memRead` / `memWrite` output 1 each, memory strobes
- `IorD` output 1, memory address select: 0 = PC, 1 = ALUOut
- `memToReg` output 1, write data select: 0 = ALUOut, 1 = MDR
- `ALUSrcA` output 1, ALU A input: 0 = PC, 1 = DataA
- `ALUSrcB` output 2, ALU B input: 00 DataB, 01 const 1, 10 sext(instr[3:0]), 11 sext(instr[7:0])
- `ALUOp` output 3, ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 pass B
- `PCWrite` output 1, PC load enable, already qualified by branch condition
- `PCSource` output 2, PC input: 00 ALU result, 01 ALUOut, 10 jump target {PC[15:12], instr[11:0]}
- `halted` output 1, high while in HALT

## Operation
- Opcodes:
  - 0x0 add, 0x1 sub, 0x2 and, 0x3 or: R-type, rd = instr[3:0]
  - 0x4 addi, 0x5 lw, 0x6 sw, 0x7 beq, 0x8 bne, 0x9 j
  - 0xA cmp: A − B written to CR, register 8
  - 0xF halt
  - 0xB–0xE illegal: treated as NOP
- States and transitions:
  - FETCH → DECODE
  - DECODE → EXEC_R (0–3) | EXEC_I (4) | MEM_ADDR (5, 6) | BRANCH (7, 8) | JUMP (9) | CMP (A) | HALT (F) | FETCH (illegal)
  - EXEC_R, EXEC_I → REG_WB → FETCH
  - MEM_ADDR → MEM_RD (lw) | MEM_WR (sw)
  - MEM_RD → MEM_WB → FETCH
  - MEM_WR → FETCH
  - BRANCH, JUMP, CMP → FETCH
  - HALT → HALT until reset
- Opcode is sampled in DECODE and held internally, so IR changes after DECODE do not alter the path.
- Outputs are Moore: a function of state and the latched opcode only. The single exception is `PCWrite` in BRANCH, which also depends on `zero`.
- Per-state asserted outputs (everything unlisted is 0):
  - FETCH: memRead, writeIR, ALUSrcB=01, ALUOp=add, PCWrite, PCSource=00
  - DECODE: ALUSrcB=11, ALUOp=add (branch target into ALUOut)
  - EXEC_R: ALUSrcA, ALUSrcB=00, ALUOp = opcode[1:0] mapped to add/sub/and/or
  - EXEC_I: ALUSrcA, ALUSrcB=10, ALUOp=add
  - MEM_ADDR: ALUSrcA, ALUSrcB=10, ALUOp=add
  - MEM_RD: memRead, IorD
  - MEM_WR: memWrite, IorD
  - MEM_WB: writeRegFile, memToReg
  - REG_WB: writeRegFile
  - BRANCH: ALUSrcA, ALUSrcB=00, ALUOp=sub, PCSource=01; PCWrite = zero (beq) or !zero (bne)
  - JUMP: PCWrite, PCSource=10
  - CMP: ALUSrcA, ALUSrcB=00, ALUOp=sub, writeRegFile, CRwrite
  - HALT: halted

## Timing
- State register updates on the rising edge of `clk`. While `reset` is high, all outputs are forced to 0.
- The first edge with `reset` high sets the state to FETCH. The first FETCH cycle is the cycle after `reset` deasserts.
- Reset mid-instruction aborts that instruction. No partial write is asserted after the reset edge.
- Cycle counts, including FETCH and DECODE:
  - R-type and addi: 4
  - lw: 5
  - sw: 4
  - beq, bne, j, cmp: 3
  - illegal: 2
- `writeIR` is high for exactly one cycle per instruction.
- `CRwrite` is never high without `writeRegFile`.
- `memRead` and `memWrite` are never high in the same cycle.

## Structure
- Shared package `cpu_pkg`: opcode constants, state enum (4-bit encoding), and the ALUOp, ALUSrcB and PCSource encodings. The datapath uses the same package.
- One module with a state register and a combinational output/next-state block. No sub-module is needed.

## Test plan
- Reset held 3 cycles with opcode=0x0 → all outputs 0; first cycle after release is FETCH: writeIR=1, PCWrite=1, memRead=1.
- opcode=0x1 (sub) → 4-cycle sequence FETCH, DECODE, EXEC_R (ALUOp=001), REG_WB (writeRegFile=1), then FETCH.
- opcode=0x5 (lw) → MEM_RD has memRead=1, IorD=1; MEM_WB has writeRegFile=1, memToReg=1; 5 cycles total.
- opcode=0x7 with zero=1 → PCWrite=1, PCSource=01 in BRANCH; with zero=0 → PCWrite=0. Reverse results for opcode=0x8.
- opcode=0xA → CMP cycle has writeRegFile=1, CRwrite=1, ALUOp=001. Opcode=0xC → back to FETCH after 2 cycles with no write enables.
- opcode=0xF → halted=1 held for 50 cycles. Reset asserted during MEM_RD of a lw → no MEM_WB write; FETCH follows reset release.
